// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and constants for the multiply/divide sequencer
package muldiv_pkg;
  typedef enum logic [1:0] {OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3} op_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIXUP = 2'd2} state_t;
  localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or restoring shift-subtract (divide) iteration on {acc, q}
// Ports: div selects divide; acc/q form the double-width working register; m is multiplicand/divisor;
//   acc_n/q_n are the updated halves.
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH:0] sum, r, diff;
  always_comb begin
    sum   = q[0] ? {1'b0, acc} + {1'b0, m} : {1'b0, acc};
    r     = {acc, q[WIDTH-1]};
    diff  = r - {1'b0, m};
    // diff[WIDTH] set means the trial subtraction borrowed: restore and shift in a 0
    acc_n = div ? (diff[WIDTH] ? r[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    q_n   = div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: multicycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
// Ports: clk, rst_n (async active-low); start/op/a/b request, taken only in IDLE; abort flushes
//   an in-flight op; mthi/mtlo/wdata write HI/LO in IDLE; busy, done (1-cycle), hi, lo registered.
// Optional: define MULDIV_FAST_MULT_EN for a single-cycle multiply (divide timing unchanged).
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, state_n;
  op_t op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, q, m, acc_s, q_s, a_abs, b_abs, quo, rem;
  logic [2*WIDTH-1:0] run_n, prod;
  logic neg_p, neg_r, sgn, divz, is_div, last, accept;
  assign sgn    = op == OP_MULT || op == OP_DIV;
  assign divz   = (op == OP_DIV || op == OP_DIVU) && b == '0;
  assign a_abs  = sgn && a[WIDTH-1] ? -a : a;
  assign b_abs  = sgn && b[WIDTH-1] ? -b : b;
  assign accept = state == S_IDLE && start && !abort;
  assign is_div = op_q == OP_DIV || op_q == OP_DIVU;
  assign busy   = state != S_IDLE;
  assign prod   = neg_p ? -{acc, q} : {acc, q};
  assign quo    = neg_p ? -q : q;
  assign rem    = neg_r ? -acc : acc;
`ifdef MULDIV_FAST_MULT_EN
  assign last  = !is_div || cnt == CNT_W'(WIDTH-1);
  assign run_n = is_div ? {acc_s, q_s} : {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, q};
`else
  assign last  = cnt == CNT_W'(WIDTH-1);
  assign run_n = {acc_s, q_s};
`endif
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div(is_div), .acc(acc), .q(q), .m(m), .acc_n(acc_s), .q_n(q_s)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = abort ? S_IDLE :
              state == S_IDLE ? (start ? (divz ? S_FIXUP : S_RUN) : S_IDLE) :
              state == S_RUN ? (last ? S_FIXUP : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_MULT;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && mthi) hi <= wdata;
      if (state == S_IDLE && mtlo) lo <= wdata;
      if (accept) begin
        op_q  <= op_t'(op);
        cnt   <= '0;
        acc   <= '0;
        // divide-by-zero keeps the raw dividend in q so FIXUP can return it in HI
        q     <= divz ? a : a_abs;
        m     <= b_abs;
        neg_p <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= sgn && a[WIDTH-1];
      end else if (state == S_RUN && !abort) begin
        {acc, q} <= run_n;
        cnt      <= cnt + CNT_W'(1);
      end else if (state == S_FIXUP && !abort) begin
        // m is zero only on the divide-by-zero path, since a real divisor magnitude is nonzero
        hi   <= is_div ? (m == '0 ? q : rem) : prod[2*WIDTH-1:WIDTH];
        lo   <= is_div ? (m == '0 ? WIDTH'(DIVZERO_LO) : quo) : prod[WIDTH-1:0];
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: randomized and directed checks of muldiv_hilo_ctrl against an arithmetic model
module tb_muldiv_hilo_ctrl;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_bad = 0;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  muldiv_hilo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, sr;
    longint unsigned ux, uy, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    eh = 32'd0;
    el = 32'd0;
    if (o == 2'd0) begin
      sr = sx * sy;
      eh = sr[63:32];
      el = sr[31:0];
    end else if (o == 2'd1) begin
      ur = ux * uy;
      eh = ur[63:32];
      el = ur[31:0];
    end else if (y == 32'd0) begin
      eh = x;
      el = 32'hFFFF_FFFF;
    end else if (o == 2'd2) begin
      sr = sx / sy;
      el = sr[31:0];
      sr = sx % sy;
      eh = sr[31:0];
    end else begin
      ur = ux / uy;
      el = ur[31:0];
      ur = ux % uy;
      eh = ur[31:0];
    end
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int lat, n;
    model(o, x, y, eh, el);
    lat = (o[1] && y == 32'd0) ? 1 : (FAST && !o[1]) ? 2 : 33;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    n = 0;
    // scramble request and MTHI/MTLO inputs while busy: all must be ignored
    while (busy && n < 100) begin
      start = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom;
      mthi = 1'($urandom); mtlo = 1'($urandom); wdata = $urandom;
      if (done) chk($sformatf("done_during_busy op%0d", o), done, 1'b0);
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk($sformatf("busy_cycles op%0d %h/%h", o, x, y), 32'(n), 32'(lat));
    chk($sformatf("done op%0d", o), {31'd0, done}, 32'd1);
    chk($sformatf("hi op%0d %h,%h", o, x, y), hi, eh);
    chk($sformatf("lo op%0d %h,%h", o, x, y), lo, el);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask
  initial begin
    logic [1:0] o;
    logic [31:0] x, y;
    #3 rst_n = 1'b0;
    #10;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op(2'd1, 32'd5, 32'd4);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd3, 32'd10, 32'd0);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0);
    // both MTHI and MTLO in IDLE
    @(negedge clk) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5; end
    @(negedge clk) begin mthi = 1'b0; mtlo = 1'b0; end
    chk("mthi_both", hi, 32'hA5A5_A5A5);
    chk("mtlo_both", lo, 32'hA5A5_A5A5);
    @(negedge clk) begin mthi = 1'b1; wdata = 32'h11; end
    @(negedge clk) begin mthi = 1'b0; mtlo = 1'b1; wdata = 32'h22; end
    @(negedge clk) mtlo = 1'b0;
    // abort mid-divide, with an MTHI attempted while busy
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    @(negedge clk) begin start = 1'b0; mthi = 1'b1; wdata = 32'hDEAD_BEEF; end
    repeat (8) @(negedge clk);
    mthi = 1'b0;
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    chk("hi_mthi_while_busy", hi, 32'h11);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    chk("abort_hi", hi, 32'h11);
    chk("abort_lo", lo, 32'h22);
    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    chk("idle_abort_prio", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op(o, x, y);
    end
    // asynchronous reset in the middle of RUN
    @(negedge clk) begin start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'h9; end
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_pre_reset", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_hi", hi, 32'd0);
    chk("async_reset_lo", lo, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op(2'd1, 32'd5, 32'd4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
